hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 12 +
 rtl/hazard_fp_timer.sv | 31 +++
 rtl/hazard_ctrl.sv | 112 +++++++++++
 tb/tb_hazard_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        FP_WAIT = 1'b1
    } state_t;

    localparam int         FP_LAT_DEFAULT = 4;
    localparam logic [3:0] REG_ZERO       = 4'd0;

endpackage : hazard_pkg

// File: rtl/hazard_fp_timer.sv
// Floating-point latency down-counter: loaded on FP entry, flags its final count.
module hazard_fp_timer
    import hazard_pkg::*;
#(
    parameter int FP_LAT = FP_LAT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic last
);

    localparam logic [3:0] LOAD_VAL = 4'(FP_LAT - 1);

    logic [3:0] fp_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            fp_cnt <= 4'd0;
        end else if (load) begin
            fp_cnt <= LOAD_VAL;
        end else if (en && fp_cnt != 4'd0) begin
            fp_cnt <= fp_cnt - 4'd1;
        end
    end

    // The entry cycle already counts as one stall, so the terminal count is 1, not 0.
    assign last = (fp_cnt == 4'd1);

endmodule : hazard_fp_timer

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: branch flush, multi-cycle FP stall and load-use bubble.
//   state   | meaning
//   RUN     | normal issue; branch / FP entry / load-use decided each cycle
//   FP_WAIT | FP op in EX; pipeline frozen until the latency timer expires
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int FP_LAT = FP_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  id_rs1,
    input  logic [3:0]  id_rs2,
    input  logic        id_use_rs2,
    input  logic        ex_mem_read,
    input  logic [3:0]  ex_rd,
    input  logic        ex_fpc,
    input  logic        branch_taken,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        fp_start,
    output logic        fp_busy,
    output logic        fp_done,
    output logic [15:0] stall_count
);

    state_t state, state_nxt;
    logic   timer_load;
    logic   timer_last;
    logic   load_use;

    assign load_use = ex_mem_read && (ex_rd != REG_ZERO) &&
                      ((ex_rd == id_rs1) || (id_use_rs2 && (ex_rd == id_rs2)));

    hazard_fp_timer #(.FP_LAT(FP_LAT)) u_fp_timer (
        .clk   (clk),
        .reset (reset),
        .load  (timer_load),
        .en    (state == FP_WAIT),
        .last  (timer_last)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        fp_start   = 1'b0;
        fp_busy    = 1'b0;
        fp_done    = 1'b0;
        timer_load = 1'b0;

        if (!reset) begin
            state_nxt  = RUN;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (ex_fpc) begin
                        fp_start   = 1'b1;
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                        timer_load = 1'b1;
                        state_nxt  = FP_WAIT;
                    end else if (load_use) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                FP_WAIT: begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    fp_busy    = 1'b1;
                    if (timer_last) begin
                        fp_done   = 1'b1;
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_count <= 16'd0;
        end else if (!pc_write && stall_count != 16'hFFFF) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: reference model, vector table, corner sequences, random traffic.
module tb_hazard_ctrl;

    localparam int FP_LAT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs2, ex_mem_read, ex_fpc, branch_taken;
    logic        pc_write, ifid_write, ifid_flush, idex_flush;
    logic        fp_start, fp_busy, fp_done;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    // Model: FP stall cycles still owed after the current one, and total stalls seen.
    int m_left   = 0;
    int m_stalls = 0;

    hazard_ctrl #(.FP_LAT(FP_LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs2   (id_use_rs2),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .ex_fpc       (ex_fpc),
        .branch_taken (branch_taken),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .fp_start     (fp_start),
        .fp_busy      (fp_busy),
        .fp_done      (fp_done),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       br;
        logic       fpc;
        logic       mr;
        logic [3:0] rd;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic       use2;
        logic [4:0] exp;   // {pc_write, ifid_write, ifid_flush, idex_flush, fp_start}
        string      name;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(input logic br, input logic fpc, input logic mr,
                                input logic [3:0] rd, input logic [3:0] rs1,
                                input logic [3:0] rs2, input logic use2,
                                input logic [4:0] e, input string n);
        vec_t v;
        v.br = br; v.fpc = fpc; v.mr = mr; v.rd = rd; v.rs1 = rs1;
        v.rs2 = rs2; v.use2 = use2; v.exp = e; v.name = n;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs after the edge, compare at the falling edge, advance model.
    task automatic cycle(input logic r, input logic br, input logic fpc, input logic mr,
                         input logic [3:0] rd, input logic [3:0] rs1,
                         input logic [3:0] rs2, input logic use2);
        logic [6:0] e;
        logic       hazard;
        logic       stall;
        @(posedge clk);
        #1;
        reset = r; branch_taken = br; ex_fpc = fpc; ex_mem_read = mr;
        ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_use_rs2 = use2;
        @(negedge clk);
        hazard = mr && rd != 4'd0 && (rd == rs1 || (use2 && rd == rs2));
        // e = {pc_write, ifid_write, ifid_flush, idex_flush, fp_start, fp_busy, fp_done}
        if (!r)               e = 7'b0011000;
        else if (m_left > 0)  e = {6'b000101, (m_left == 1)};
        else if (br)          e = 7'b1111000;
        else if (fpc)         e = 7'b0001100;
        else if (hazard)      e = 7'b0001000;
        else                  e = 7'b1100000;
        check("outputs", {9'd0, pc_write, ifid_write, ifid_flush, idex_flush,
                          fp_start, fp_busy, fp_done}, {9'd0, e});
        check("stall_count", stall_count, 16'(m_stalls));
        stall = !e[6];
        if (!r) begin
            m_left = 0; m_stalls = 0;
        end else begin
            if (m_left > 0)                m_left--;
            else if (!br && fpc)           m_left = FP_LAT - 1;
            if (stall && m_stalls < 65535) m_stalls++;
        end
    endtask

    task automatic idle(input logic r);
        cycle(r, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    endtask

    initial begin
        reset = 1'b0; branch_taken = 1'b0; ex_fpc = 1'b0; ex_mem_read = 1'b0;
        ex_rd = 4'd0; id_rs1 = 4'd0; id_rs2 = 4'd0; id_use_rs2 = 1'b0;

        vecs[0] = mk(1'b0, 1'b0, 1'b0, 4'd3, 4'd3, 4'd0, 1'b0, 5'b11000, "idle");
        vecs[1] = mk(1'b0, 1'b0, 1'b1, 4'd3, 4'd3, 4'd0, 1'b0, 5'b00010, "lu_rs1");
        vecs[2] = mk(1'b0, 1'b0, 1'b1, 4'd6, 4'd1, 4'd6, 1'b1, 5'b00010, "lu_rs2");
        vecs[3] = mk(1'b0, 1'b0, 1'b1, 4'd5, 4'd1, 4'd5, 1'b0, 5'b11000, "rs2_gated");
        vecs[4] = mk(1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 1'b1, 5'b11000, "reg_zero");
        vecs[5] = mk(1'b0, 1'b0, 1'b0, 4'd3, 4'd3, 4'd3, 1'b1, 5'b11000, "no_load");
        vecs[6] = mk(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 5'b11110, "branch");
        vecs[7] = mk(1'b1, 1'b1, 1'b1, 4'd3, 4'd3, 4'd0, 1'b0, 5'b11110, "br_fp_lu");
        vecs[8] = mk(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 5'b00011, "fp");
        vecs[9] = mk(1'b0, 1'b1, 1'b1, 4'd3, 4'd3, 4'd0, 1'b0, 5'b00011, "fp_lu");

        // Reset values
        idle(1'b0);
        idle(1'b0);
        check("rst_stall_count", stall_count, 16'd0);
        idle(1'b1);
        check("first_run_pc_write", {15'd0, pc_write}, 16'd1);

        // Vector table
        foreach (vecs[i]) begin
            cycle(1'b1, vecs[i].br, vecs[i].fpc, vecs[i].mr, vecs[i].rd,
                  vecs[i].rs1, vecs[i].rs2, vecs[i].use2);
            check(vecs[i].name, {11'd0, pc_write, ifid_write, ifid_flush, idex_flush, fp_start},
                  {11'd0, vecs[i].exp});
            repeat (FP_LAT) idle(1'b1);
        end

        // Load-use hit lasts one cycle
        idle(1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 4'd3, 4'd0, 1'b0);
        check("lu_pc_write", {15'd0, pc_write}, 16'd0);
        check("lu_idex_flush", {15'd0, idex_flush}, 16'd1);
        idle(1'b1);
        check("lu_release", {15'd0, pc_write}, 16'd1);
        check("lu_count", stall_count, 16'd1);

        // FP op: stall FP_LAT cycles, inputs ignored during FP_WAIT
        idle(1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        check("fp_start", {15'd0, fp_start}, 16'd1);
        for (int k = 2; k <= FP_LAT; k++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 4'd2, 4'd2, 1'b1);
            check("fp_wait_pc", {15'd0, pc_write}, 16'd0);
            check("fp_wait_busy", {15'd0, fp_busy}, 16'd1);
            check("fp_done_cycle", {15'd0, fp_done}, {15'd0, (k == FP_LAT)});
            check("fp_wait_no_flush", {15'd0, ifid_flush}, 16'd0);
        end
        idle(1'b1);
        check("fp_resume", {14'd0, pc_write, fp_start}, 16'b10);
        check("fp_count", stall_count, 16'(FP_LAT));

        // Branch wins over FP
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        check("brfp", {12'd0, ifid_flush, idex_flush, fp_start, pc_write}, 16'b1101);
        idle(1'b1);
        check("brfp_stays_run", {14'd0, fp_busy, pc_write}, 16'b01);

        // Reset in FP_WAIT cycle 2 aborts the op
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
        idle(1'b1);
        check("abort_pre_busy", {15'd0, fp_busy}, 16'd1);
        idle(1'b0);
        check("abort_busy_done", {14'd0, fp_busy, fp_done}, 16'd0);
        idle(1'b1);
        check("abort_count", stall_count, 16'd0);
        check("abort_run", {14'd0, pc_write, fp_busy}, 16'b10);
        repeat (FP_LAT) begin
            idle(1'b1);
            check("abort_no_done", {15'd0, fp_done}, 16'd0);
        end

        // Randomized traffic
        for (int n = 0; n < 2000; n++) begin
            cycle(($urandom_range(31) != 0), ($urandom_range(7) == 0),
                  ($urandom_range(7) == 0), 1'($urandom),
                  4'($urandom_range(3)), 4'($urandom_range(3)),
                  4'($urandom_range(3)), 1'($urandom));
        end

        // Saturation
        idle(1'b0);
        for (int n = 0; n < 70000; n++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 4'd3, 4'd0, 1'b0);
        end
        idle(1'b1);
        check("saturated", stall_count, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_hazard_ctrl
